// File: rtl/crc_check_if.sv
// Codeword handshake bundle for crc_check: received codeword in, checked payload out.
// The checker uses the slave modport; the upstream/downstream side uses master.
interface crc_check_if;
  logic [35:0] d_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] d_out;
  logic [3:0]  syndrome;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output d_in, in_valid, out_ready,
    input  in_ready, d_out, syndrome, err, out_valid
  );

  modport slave (
    input  d_in, in_valid, out_ready,
    output in_ready, d_out, syndrome, err, out_valid
  );
endinterface

// File: rtl/crc_check.sv
// crc_check: receive-side CRC-4 (x^4+x+1) checker with a one-entry output register
// and link statistics (wrapping word count, saturating error count, sticky error flag).
module crc_check #(
  parameter int CNT_W    = 16,
  parameter int DROP_ERR = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  crc_check_if.slave       bus,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic             o_err_sticky
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             DROP    = (DROP_ERR != 0);

  // Long division of the whole codeword, MSB first; feedback taps are the low bits of 10011.
  function automatic logic [3:0] crc4_rem(input logic [35:0] cw);
    logic [3:0] rem;
    rem = 4'b0000;
    for (int i = 35; i >= 0; i--) begin
      rem = {rem[2:0], cw[i]} ^ (rem[3] ? 4'b0011 : 4'b0000);
    end
    return rem;
  endfunction

  logic [3:0]       w_syndrome;
  logic             w_syn_nz;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_load;
  logic             w_drain;

  logic             r_out_valid;
  logic [31:0]      r_d_out;
  logic [3:0]       r_syndrome;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_word_cnt;
  logic             r_err_sticky;

  assign w_syndrome = crc4_rem(bus.d_in);
  assign w_syn_nz   = (w_syndrome != 4'b0000);
  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;
  // A dropped word is still accepted and counted, it just never reaches the register.
  assign w_load     = w_accept & ~(DROP & w_syn_nz);
  assign w_drain    = r_out_valid & bus.out_ready;

  // Output register: load on accept, otherwise release once downstream takes the word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_d_out     <= 32'h0000_0000;
      r_syndrome  <= 4'b0000;
      r_err       <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_d_out     <= bus.d_in[35:4];
      r_syndrome  <= w_syndrome;
      r_err       <= w_syn_nz;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Statistics: clear wins over any accept in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt    <= '0;
      r_word_cnt   <= '0;
      r_err_sticky <= 1'b0;
    end else if (i_clr_cnt) begin
      r_err_cnt    <= '0;
      r_word_cnt   <= '0;
      r_err_sticky <= 1'b0;
    end else if (w_accept) begin
      r_word_cnt   <= r_word_cnt + CNT_ONE;
      r_err_cnt    <= (w_syn_nz && !(&r_err_cnt)) ? (r_err_cnt + CNT_ONE) : r_err_cnt;
      r_err_sticky <= r_err_sticky | w_syn_nz;
    end else begin
      r_err_cnt    <= r_err_cnt;
      r_word_cnt   <= r_word_cnt;
      r_err_sticky <= r_err_sticky;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.d_out     = r_d_out;
  assign bus.syndrome  = r_syndrome;
  assign bus.err       = r_err;
  assign o_err_cnt     = r_err_cnt;
  assign o_word_cnt    = r_word_cnt;
  assign o_err_sticky  = r_err_sticky;

endmodule
